// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: locks onto hsync/vsync, emits active-area coordinates and pixels.
// Optional error counter enabled by defining VGA_SYNC_DECODER_ERRCNT_EN.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned V_END   = V_START + V_ACTIVE - 1;

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  state_t          state;
  logic            s1_hs, s1_vs, s1_hs_d, s1_vs_d;
  logic [15:0]     s1_rgb;
  logic [HW-1:0]   h_cnt, h_nx_c;
  logic [VW-1:0]   v_cnt, v_nx_c;
  logic            h_edge_c, v_edge_c;
  logic            line_bad_c, frame_bad_c, mismatch_c, live_err_c;
  logic            in_win_c, keep_lock_c, first_pix_c;

  // Edge detection, counter next values, timing checks and window decode
  always_comb begin
    h_edge_c    = (s1_hs == SYNC_POL) && (s1_hs_d != SYNC_POL);
    v_edge_c    = (s1_vs == SYNC_POL) && (s1_vs_d != SYNC_POL);
    h_nx_c      = h_cnt;
    v_nx_c      = v_cnt;
    if (h_edge_c)
      h_nx_c = '0;
    else if (h_cnt != '1)
      h_nx_c = h_cnt + HW'(1);
    if (v_edge_c)
      v_nx_c = '0;
    else if (h_edge_c)
      v_nx_c = v_cnt + VW'(1);
    // Without an edge, stepping past H_TOTAL-1 is a line timeout
    line_bad_c  = h_edge_c ? (h_cnt != HW'(H_TOTAL - 1)) : (h_cnt == HW'(H_TOTAL - 1));
    frame_bad_c = v_edge_c && (v_cnt != VW'(V_TOTAL - 1));
    mismatch_c  = line_bad_c || frame_bad_c;
    live_err_c  = mismatch_c && (state != SEEK);
    in_win_c    = (h_nx_c >= HW'(H_START)) && (h_nx_c <= HW'(H_END)) &&
                  (v_nx_c >= VW'(V_START)) && (v_nx_c <= VW'(V_END));
    // True exactly when the next state is LOCKED
    keep_lock_c = !mismatch_c &&
                  ((state == LOCKED) || ((state == TRACK) && v_edge_c));
    first_pix_c = (h_nx_c == HW'(H_START)) && (v_nx_c == VW'(V_START));
  end

  // Stage 1 capture, counters, FSM and stage 2 outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_hs_d     <= 1'b0;
      s1_vs_d     <= 1'b0;
      s1_rgb      <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= SEEK;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      s1_hs   <= hsync;
      s1_vs   <= vsync;
      s1_hs_d <= s1_hs;
      s1_vs_d <= s1_vs;
      s1_rgb  <= rgb;
      h_cnt   <= h_nx_c;
      v_cnt   <= v_nx_c;

      case (state)
        SEEK:    if (v_edge_c) state <= TRACK;
        TRACK:   if (mismatch_c) state <= SEEK;
                 else if (v_edge_c) state <= LOCKED;
        LOCKED:  if (mismatch_c) state <= SEEK;
        default: state <= SEEK;
      endcase

      locked      <= keep_lock_c;
      err         <= live_err_c;
      pix_valid   <= keep_lock_c && in_win_c;
      frame_start <= keep_lock_c && in_win_c && first_pix_c;
      if (keep_lock_c && in_win_c) begin
        pix_x    <= 10'(h_nx_c - HW'(H_START));
        pix_y    <= 10'(v_nx_c - VW'(V_START));
        pix_data <= s1_rgb;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  // Saturating count of reported mismatches; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (live_err_c && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: hsync pulse width, in clocks.
REQ-002 SHALL have parameter H_BACK, default 48: back porch, in clocks.
REQ-003 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800: clocks per line.
REQ-005 SHALL have parameters V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_TOTAL 525: the vertical equivalents of REQ-001..004, in lines.
REQ-006 SHALL have parameter SYNC_POL, default 1: asserted level of hsync and vsync.
REQ-007 Port clk, input, 1: pixel clock; the only clock.
REQ-008 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 Port hsync, input, 1: horizontal sync; synchronous to clk.
REQ-010 Port vsync, input, 1: vertical sync; synchronous to clk.
REQ-011 Port rgb, input, 16: RGB565 pixel data.
REQ-012 Port pix_x, output, 10: active-area column.
REQ-013 Port pix_y, output, 10: active-area row.
REQ-014 Port pix_data, output, 16: captured pixel.
REQ-015 Port pix_valid, output, 1: pix_x, pix_y and pix_data are valid.
REQ-016 Port frame_start, output, 1: one-clock pulse, marks the first active pixel of a frame.
REQ-017 Port locked, output, 1: timing lock status.
REQ-018 Port err, output, 1: one-clock pulse on a timing mismatch.
REQ-019 Port err_cnt, output, 8: error counter; see Configuration.

Function
REQ-020 Stage 1 SHALL register hsync, vsync and rgb every clock; stage 2 SHALL register all outputs.
- Pipeline latency, input to output: 2 clocks.
- pix_data SHALL be aligned with pix_x and pix_y.
REQ-021 A leading edge is defined as: the stage-1 sync value equals SYNC_POL and the previous value does not.
REQ-022 h_cnt (11-bit) SHALL be 0 on an hsync leading edge, otherwise increment, saturating at 2047.
REQ-023 v_cnt (10-bit) SHALL be 0 on a vsync leading edge, otherwise increment on each hsync leading edge.
- When both edges occur in the same clock, both counters SHALL be 0.
REQ-024 Line check, at each hsync leading edge:
- Good if h_cnt == H_TOTAL-1, otherwise mismatch.
- If h_cnt reaches H_TOTAL with no edge, that is a mismatch (timeout).
REQ-025 Frame check, at each vsync leading edge:
- Good if v_cnt == V_TOTAL-1, otherwise mismatch.
REQ-026 The FSM SHALL have three states: SEEK, TRACK, LOCKED.
- SEEK -> TRACK on a vsync leading edge.
- TRACK -> LOCKED on a good frame check with all lines of that frame good.
- TRACK or LOCKED -> SEEK on any mismatch.
- A mismatch and a vsync edge in the same clock: the mismatch wins, and the next state is SEEK.
REQ-027 locked SHALL be 1 only in state LOCKED.
REQ-028 err SHALL pulse for one clock on each mismatch detected in TRACK or LOCKED.
- Mismatches in SEEK SHALL be ignored.
REQ-029 The active window SHALL be h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
REQ-030 pix_valid SHALL be 1 only for pixels inside the active window while in LOCKED.
- The first frame after acquisition therefore produces no pixels.
REQ-031 Coordinates: pix_x = h_cnt-(H_SYNC+H_BACK), pix_y = v_cnt-(V_SYNC+V_BACK).
- Outside pix_valid, pix_x, pix_y and pix_data SHALL hold their last values.
REQ-032 frame_start SHALL pulse together with pix_valid at pix_x=0, pix_y=0.
REQ-033 On a transition to SEEK, pix_valid SHALL deassert on the very next output clock.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in SEEK; h_cnt=0; v_cnt=0; all stage-1 registers 0.
REQ-035 While rst_n=0, outputs SHALL be: pix_x=0, pix_y=0, pix_data=0, pix_valid=0, frame_start=0, locked=0, err=0, err_cnt=0.
REQ-036 Reset asserted mid-frame SHALL take effect immediately.
- After release, lock SHALL require a new vsync edge plus one full good frame.

Configuration
REQ-037 Macro VGA_SYNC_DECODER_ERRCNT_EN.
- Defined: err_cnt counts err pulses, saturates at 255, and clears only on reset.
- Undefined: err_cnt is tied to 0 and no counter register is built.

Verification
REQ-038 640x480 generator at 800x525 timing, two frames -> locked=1 from frame 2 onward.
- Exactly 307200 pix_valid pulses in frame 2.
- Exactly one frame_start per frame.
REQ-039 Ramp rgb = h position -> at pix_x=0 pix_data=144; at pix_x=639 pix_data=783.
- Both appear 2 clocks after the sample.
REQ-040 One line shortened to 799 clocks while locked -> err pulses once; locked=0 the next clock; pix_valid stops.
- Lock returns after the next vsync edge plus one good frame.
REQ-041 Stuck hsync while locked -> err at h_cnt=800; FSM goes to SEEK; no further err pulses until re-tracking.
REQ-042 Reset pulse mid-line in frame 3 -> all outputs 0 in the same clock; locked=1 again only after one full frame.
REQ-043 With VGA_SYNC_DECODER_ERRCNT_EN defined: 300 injected mismatches -> err_cnt=255.
- Undefined: err_cnt stays 0.
